// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: handles load-use bubbles, memory freezes,
// taken-branch squashes and halt draining, and keeps saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       ARS1_IF_ID,
  input  logic [4:0]       ARS2_IF_ID,
  input  logic             USE_RS1_IF_ID,
  input  logic             USE_RS2_IF_ID,
  input  logic [4:0]       ARD_ID_EX,
  input  logic             MEMREAD_ID_EX,
  input  logic             BRANCH_TAKEN_EX,
  input  logic             DMEM_REQ,
  input  logic             DMEM_READY,
  input  logic             HALT_REQ,
  input  logic             RESUME,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             ID_EX_EN,
  output logic             EX_MEM_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             MEM_WB_BUBBLE,
  output logic             PC_REDIRECT,
  output logic             HALTED,
  output logic             MEM_TIMEOUT,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED} state_t;

  state_t            state_q, state_d, ret_q, ret_d, eff_s;
  logic [WW-1:0]     wait_q, wait_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              stall_ev, flush_ev;
  logic              freeze, loaduse;

  assign freeze  = DMEM_REQ & ~DMEM_READY;
  assign loaduse = MEMREAD_ID_EX & (ARD_ID_EX != 5'd0) &
                   ((USE_RS1_IF_ID & (ARD_ID_EX == ARS1_IF_ID)) |
                    (USE_RS2_IF_ID & (ARD_ID_EX == ARS2_IF_ID)));
  // Once the wait ends, the cycle behaves as the state that was interrupted.
  assign eff_s   = (state_q == S_MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    PC_EN         = 1'b1;
    IF_ID_EN      = 1'b1;
    ID_EX_EN      = 1'b1;
    EX_MEM_EN     = 1'b1;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    MEM_WB_BUBBLE = 1'b0;
    PC_REDIRECT   = 1'b0;
    state_d       = state_q;
    ret_d         = ret_q;
    wait_d        = '0;
    drain_d       = drain_q;
    timeout_d     = timeout_q;
    flush_ev      = 1'b0;
    if (!RST_N) begin
      PC_EN         = 1'b0;
      IF_ID_EN      = 1'b0;
      ID_EX_EN      = 1'b0;
      EX_MEM_EN     = 1'b0;
      IF_ID_FLUSH   = 1'b1;
      ID_EX_FLUSH   = 1'b1;
      MEM_WB_BUBBLE = 1'b1;
    end else if (eff_s == S_HALTED) begin
      PC_EN         = 1'b0;
      IF_ID_FLUSH   = 1'b1;
      ID_EX_FLUSH   = 1'b1;
      MEM_WB_BUBBLE = 1'b1;
      if (RESUME) state_d = S_RUN;
    end else if (freeze) begin
      PC_EN         = 1'b0;
      IF_ID_EN      = 1'b0;
      ID_EX_EN      = 1'b0;
      EX_MEM_EN     = 1'b0;
      MEM_WB_BUBBLE = 1'b1;
      state_d       = S_MEM_WAIT;
      if (state_q != S_MEM_WAIT) ret_d = state_q;
      wait_d = (wait_q == WW'(TIMEOUT)) ? wait_q : wait_q + WW'(1);
      if (wait_d == WW'(TIMEOUT)) timeout_d = 1'b1;
    end else if (eff_s == S_DRAIN) begin
      PC_EN       = 1'b0;
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
      if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
        state_d = S_HALTED;
      end else begin
        state_d = S_DRAIN;
        drain_d = drain_q + DW'(1);
      end
    end else begin
      state_d = S_RUN;
      if (BRANCH_TAKEN_EX) begin
        PC_REDIRECT = 1'b1;
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        flush_ev    = 1'b1;
      end else if (loaduse) begin
        PC_EN       = 1'b0;
        IF_ID_EN    = 1'b0;
        ID_EX_FLUSH = 1'b1;
      end else if (HALT_REQ) begin
        // Halt moves on into EX while fetch stops; the drain starts next cycle.
        PC_EN       = 1'b0;
        IF_ID_FLUSH = 1'b1;
        state_d     = S_DRAIN;
        drain_d     = '0;
      end
    end
    stall_ev = RST_N & ~PC_EN & (state_q != S_HALTED);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_RUN;
      ret_q     <= S_RUN;
      wait_q    <= '0;
      drain_q   <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      timeout_q <= timeout_d;
      if (stall_ev && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_ev && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign HALTED      = (state_q == S_HALTED);
  assign MEM_TIMEOUT = timeout_q;
  assign STALL_CNT   = stall_q;
  assign FLUSH_CNT   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: expected control/status values are queued
// per cycle and compared against the DUT a moment after the inputs are applied.
module tb_pipeline_hazard_controller;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [4:0]  ARS1_IF_ID, ARS2_IF_ID, ARD_ID_EX;
  logic        USE_RS1_IF_ID, USE_RS2_IF_ID, MEMREAD_ID_EX, BRANCH_TAKEN_EX;
  logic        DMEM_REQ, DMEM_READY, HALT_REQ, RESUME;
  logic        PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN;
  logic        IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_BUBBLE, PC_REDIRECT;
  logic        HALTED, MEM_TIMEOUT;
  logic [31:0] STALL_CNT, FLUSH_CNT;

  pipeline_hazard_controller #(.DRAIN_CYCLES(3), .TIMEOUT(64), .CNT_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ARS1_IF_ID(ARS1_IF_ID), .ARS2_IF_ID(ARS2_IF_ID),
    .USE_RS1_IF_ID(USE_RS1_IF_ID), .USE_RS2_IF_ID(USE_RS2_IF_ID),
    .ARD_ID_EX(ARD_ID_EX), .MEMREAD_ID_EX(MEMREAD_ID_EX),
    .BRANCH_TAKEN_EX(BRANCH_TAKEN_EX), .DMEM_REQ(DMEM_REQ), .DMEM_READY(DMEM_READY),
    .HALT_REQ(HALT_REQ), .RESUME(RESUME),
    .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN), .ID_EX_EN(ID_EX_EN), .EX_MEM_EN(EX_MEM_EN),
    .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH), .MEM_WB_BUBBLE(MEM_WB_BUBBLE),
    .PC_REDIRECT(PC_REDIRECT), .HALTED(HALTED), .MEM_TIMEOUT(MEM_TIMEOUT),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  // {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_BUBBLE, PC_REDIRECT}
  localparam logic [7:0] C_DEF  = 8'b1111_0000;
  localparam logic [7:0] C_FRZ  = 8'b0000_0010;
  localparam logic [7:0] C_BR   = 8'b1111_1101;
  localparam logic [7:0] C_LU   = 8'b0011_0100;
  localparam logic [7:0] C_HACC = 8'b0111_1000;
  localparam logic [7:0] C_DRN  = 8'b0111_1100;
  localparam logic [7:0] C_HLT  = 8'b0111_1110;
  localparam logic [7:0] C_RST  = 8'b0000_1110;

  typedef struct packed {
    logic [7:0]  ctl;
    logic        halted;
    logic        tmo;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_stall  = 0;
  logic [31:0] m_flush  = 0;
  logic [7:0]  ctl_obs;

  assign ctl_obs = {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN,
                    IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_BUBBLE, PC_REDIRECT};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    ARS1_IF_ID = 0; ARS2_IF_ID = 0; ARD_ID_EX = 0;
    USE_RS1_IF_ID = 0; USE_RS2_IF_ID = 0; MEMREAD_ID_EX = 0; BRANCH_TAKEN_EX = 0;
    DMEM_REQ = 0; DMEM_READY = 0; HALT_REQ = 0; RESUME = 0;
  endtask

  // Inputs are already applied (at the falling edge); queue this cycle's expectation,
  // compare shortly after, then advance the counter model across the next rising edge.
  task automatic step(input string tag, input logic [7:0] ectl, input logic eh, input logic eto);
    exp_t e;
    sb.push_back('{ctl: ectl, halted: eh, tmo: eto, stall: m_stall, flush: m_flush});
    #1;
    e = sb.pop_front();
    chk({tag, ".ctl"},    {24'd0, ctl_obs},     {24'd0, e.ctl});
    chk({tag, ".halted"}, {31'd0, HALTED},      {31'd0, e.halted});
    chk({tag, ".tmo"},    {31'd0, MEM_TIMEOUT}, {31'd0, e.tmo});
    chk({tag, ".stall"},  STALL_CNT,            e.stall);
    chk({tag, ".flush"},  FLUSH_CNT,            e.flush);
    if (!RST_N) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!ectl[7] && !eh) m_stall++;
      if (ectl[0]) m_flush++;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    step("reset", C_RST, 1'b0, 1'b0);
    RST_N = 1'b1;
    step("idle", C_DEF, 1'b0, 1'b0);

    // Load-use on rs1: one bubble, then clear.
    MEMREAD_ID_EX = 1; ARD_ID_EX = 5; ARS1_IF_ID = 5; USE_RS1_IF_ID = 1;
    step("lu_rs1", C_LU, 1'b0, 1'b0);
    idle();
    step("lu_after", C_DEF, 1'b0, 1'b0);

    // Load to x0 never stalls.
    MEMREAD_ID_EX = 1; ARD_ID_EX = 0; ARS1_IF_ID = 0; USE_RS1_IF_ID = 1;
    step("lu_x0", C_DEF, 1'b0, 1'b0);
    // rs2 matches but is not used.
    ARD_ID_EX = 7; ARS1_IF_ID = 3; ARS2_IF_ID = 7; USE_RS2_IF_ID = 0;
    step("lu_rs2_unused", C_DEF, 1'b0, 1'b0);
    USE_RS2_IF_ID = 1;
    step("lu_rs2", C_LU, 1'b0, 1'b0);
    idle();
    step("idle2", C_DEF, 1'b0, 1'b0);

    // Branch held in EX across a 4-cycle memory freeze.
    DMEM_REQ = 1; DMEM_READY = 0; BRANCH_TAKEN_EX = 1;
    for (int i = 0; i < 4; i++) step("frz_br", C_FRZ, 1'b0, 1'b0);
    DMEM_READY = 1;
    step("br_after_frz", C_BR, 1'b0, 1'b0);
    idle();
    step("idle3", C_DEF, 1'b0, 1'b0);

    // Branch beats a wrong-path load-use and halt.
    BRANCH_TAKEN_EX = 1; MEMREAD_ID_EX = 1; ARD_ID_EX = 9; ARS1_IF_ID = 9;
    USE_RS1_IF_ID = 1; HALT_REQ = 1;
    step("br_prio", C_BR, 1'b0, 1'b0);
    // Load-use beats halt.
    BRANCH_TAKEN_EX = 0;
    step("lu_prio", C_LU, 1'b0, 1'b0);
    idle();
    step("idle4", C_DEF, 1'b0, 1'b0);

    // Plain halt: accept, three drain cycles, halted, resume.
    HALT_REQ = 1;
    step("halt_acc", C_HACC, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) step("drain", C_DRN, 1'b0, 1'b0);
    step("halted", C_HLT, 1'b1, 1'b0);
    step("halted_hold", C_HLT, 1'b1, 1'b0);
    RESUME = 1;
    step("resume", C_HLT, 1'b1, 1'b0);
    RESUME = 0;
    step("run_again", C_DEF, 1'b0, 1'b0);

    // Halt with a 2-cycle freeze inside the drain: halted arrives 2 cycles later.
    HALT_REQ = 1;
    step("halt2_acc", C_HACC, 1'b0, 1'b0);
    idle();
    DMEM_REQ = 1; DMEM_READY = 0;
    step("drain_frz0", C_FRZ, 1'b0, 1'b0);
    step("drain_frz1", C_FRZ, 1'b0, 1'b0);
    DMEM_READY = 1;
    step("drain2_0", C_DRN, 1'b0, 1'b0);
    idle();
    step("drain2_1", C_DRN, 1'b0, 1'b0);
    step("drain2_2", C_DRN, 1'b0, 1'b0);
    step("halted2", C_HLT, 1'b1, 1'b0);
    RESUME = 1;
    step("resume2", C_HLT, 1'b1, 1'b0);
    RESUME = 0;
    step("run_again2", C_DEF, 1'b0, 1'b0);

    // Memory timeout after 64 consecutive wait cycles, sticky afterwards.
    DMEM_REQ = 1; DMEM_READY = 0;
    for (int i = 0; i < 64; i++) step("tmo_wait", C_FRZ, 1'b0, 1'b0);
    DMEM_READY = 1;
    step("tmo_set", C_DEF, 1'b1 & 1'b0, 1'b1);
    idle();
    step("tmo_sticky", C_DEF, 1'b0, 1'b1);

    // One reset edge clears everything.
    RST_N = 1'b0;
    step("reset2", C_RST, 1'b0, 1'b1);
    RST_N = 1'b1;
    step("post_reset", C_DEF, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It works alongside the EX-stage forwarding unit.
- Resolves load-use hazards that forwarding cannot cover.
- Freezes the pipeline while data memory is busy.
- Squashes wrong-path instructions on taken branches.
- Drains and halts the core on a halt instruction.
- Keeps saturating stall and flush performance counters.

Parameters:
DRAIN_CYCLES, 3, non-frozen cycles after halt acceptance until the pipeline is empty (ID/EX through MEM/WB)
TIMEOUT, 64, consecutive memory-wait cycles before MEM_TIMEOUT is raised
CNT_W, 32, width of the performance counters

Ports:
CLK  input  1  clock; all state updates on rising edge
RST_N  input  1  synchronous reset, active low
ARS1_IF_ID  input  5  rs1 address of instruction in ID
ARS2_IF_ID  input  5  rs2 address of instruction in ID
USE_RS1_IF_ID  input  1  ID instruction reads rs1
USE_RS2_IF_ID  input  1  ID instruction reads rs2
ARD_ID_EX  input  5  rd of instruction in EX
MEMREAD_ID_EX  input  1  EX instruction is a load
BRANCH_TAKEN_EX  input  1  EX resolved a taken branch/jump
DMEM_REQ  input  1  MEM-stage instruction accesses data memory
DMEM_READY  input  1  data memory completes the access this cycle
HALT_REQ  input  1  ID instruction is a halt
RESUME  input  1  leave HALTED
PC_EN  output  1  PC register write enable
IF_ID_EN  output  1  IF/ID register write enable
ID_EX_EN  output  1  ID/EX register write enable
EX_MEM_EN  output  1  EX/MEM register write enable
IF_ID_FLUSH  output  1  load NOP into IF/ID
ID_EX_FLUSH  output  1  load NOP (all control bits 0) into ID/EX
MEM_WB_BUBBLE  output  1  load NOP into MEM/WB
PC_REDIRECT  output  1  select branch target for PC
HALTED  output  1  core halted
MEM_TIMEOUT  output  1  sticky memory-timeout error
STALL_CNT  output  CNT_W  cycles with PC_EN=0 while not HALTED, saturating
FLUSH_CNT  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- Control outputs are combinational from state and inputs. State, counters, HALTED and MEM_TIMEOUT are registered.
- Reset (RST_N=0 at edge):
  - state=RUN, all counters 0, HALTED=0, MEM_TIMEOUT=0.
  - While RST_N=0, combinationally: all *_EN=0, IF_ID_FLUSH=ID_EX_FLUSH=MEM_WB_BUBBLE=1, PC_REDIRECT=0.
- Default (no event): all *_EN=1, flushes/bubble/redirect=0.
- Conditions:
  - freeze = DMEM_REQ & !DMEM_READY
  - loaduse = MEMREAD_ID_EX & ARD_ID_EX!=0 & ((USE_RS1_IF_ID & ARD_ID_EX==ARS1_IF_ID) | (USE_RS2_IF_ID & ARD_ID_EX==ARS2_IF_ID))
- Priority per cycle: freeze > branch > loaduse > halt.
- freeze: PC_EN=IF_ID_EN=ID_EX_EN=EX_MEM_EN=0, MEM_WB_BUBBLE=1. No flush, no redirect. A branch held in EX is re-evaluated after the freeze.
- branch (no freeze): PC_REDIRECT=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, FLUSH_CNT+1. A load-use or halt in ID is ignored because it is wrong-path.
- loaduse (no freeze, no branch): PC_EN=IF_ID_EN=0, ID_EX_FLUSH=1. This costs exactly one bubble, because the next cycle the load is in MEM and the forwarding unit covers it.
- States:
  - RUN:
    - freeze -> MEM_WAIT.
    - HALT_REQ accepted (no freeze/branch/loaduse) -> DRAIN. In the acceptance cycle the halt advances into EX, PC_EN=0, IF_ID_FLUSH=1, drain counter loads 0.
  - MEM_WAIT:
    - Wait counter increments each freeze cycle. When it reaches TIMEOUT, set MEM_TIMEOUT (stays set until reset) and remain in MEM_WAIT.
    - !freeze -> return to the state held before the wait (RUN or DRAIN); wait counter clears.
  - DRAIN:
    - PC_EN=0, IF_ID_FLUSH=1, ID_EX_FLUSH=1. Downstream stages are enabled.
    - Drain counter increments on non-frozen cycles only. freeze -> MEM_WAIT, with return to DRAIN.
    - Counter==DRAIN_CYCLES-1 on a non-frozen cycle -> HALTED.
  - HALTED:
    - HALTED=1, PC_EN=0, IF_ID_FLUSH=ID_EX_FLUSH=MEM_WB_BUBBLE=1.
    - RESUME -> RUN next cycle, with HALTED=0 in that cycle.
- Counters:
  - STALL_CNT increments on any cycle with PC_EN=0 and state!=HALTED (includes DRAIN).
  - Both counters saturate at all-ones and never wrap.
- Loaduse with ARD_ID_EX=0 or with the unused rs field matching: no stall.

Test Plan:
- Load x5 in EX, ID add reads rs1=x5, USE_RS1=1 -> one cycle PC_EN=IF_ID_EN=0, ID_EX_FLUSH=1, STALL_CNT=1; next cycle all EN=1.
- Load to x0 in EX, ID reads x0 -> no stall; same match with USE_RS2=0 on rs2 -> no stall.
- DMEM_REQ=1, DMEM_READY=0 for 4 cycles with BRANCH_TAKEN_EX=1 throughout -> 4 cycles all EN=0, MEM_WB_BUBBLE=1, PC_REDIRECT=0. On the ready cycle: PC_REDIRECT=1, both flushes=1, FLUSH_CNT=1.
- HALT_REQ in RUN, no hazards -> DRAIN for 3 cycles (PC_EN=0), HALTED=1 on the 4th edge. RESUME=1 -> RUN next cycle.
- Halt accepted, then 2-cycle freeze during DRAIN -> HALTED asserts 2 cycles later than without the freeze.
- DMEM_READY held 0 for TIMEOUT=64 cycles -> MEM_TIMEOUT=1 and remains 1 after READY. RST_N=0 for one edge -> all registered outputs and counters 0, state RUN.
